// File: rtl/compare_pipe.sv
// Two-stage valid/ready branch/set-condition comparator: stage 1 registers A-B flags, stage 2 the result.
// Optional build macro CMP_UNSIGNED_EN makes function code 011 a legal unsigned less-than (LTU).
module compare_pipe #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2:0]           ft_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 s_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 err_o,
  input  logic                 err_clr
);

  localparam logic [2:0] FT_NEQ = 3'b000;
  localparam logic [2:0] FT_EQ  = 3'b001;
  localparam logic [2:0] FT_LT  = 3'b010;
  localparam logic [2:0] FT_LTU = 3'b011;
  localparam logic [2:0] FT_GEZ = 3'b100;
  localparam logic [2:0] FT_LEZ = 3'b110;
  localparam logic [2:0] FT_GTZ = 3'b111;

  logic [WIDTH-1:0]     diff;
  logic                 z_next, n_next, v_next;
  logic                 s1_valid_reg, z_reg, n_reg, v_reg;
  logic [2:0]           ft1_reg;
  logic [TAG_WIDTH-1:0] tag1_reg;
  logic                 s2_valid_reg, s_reg, err_reg;
  logic [TAG_WIDTH-1:0] tag2_reg;
  logic                 adv1, adv2;
  logic                 lt, s_next, illegal;
`ifdef CMP_UNSIGNED_EN
  logic                 c_next, c_reg;
`endif

  assign diff   = a_i - b_i;
  assign z_next = (diff == '0);
  assign n_next = diff[WIDTH-1];
  // Signed overflow: operands of opposite sign and the result sign differs from A.
  assign v_next = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (diff[WIDTH-1] != a_i[WIDTH-1]);
`ifdef CMP_UNSIGNED_EN
  assign c_next = (a_i < b_i);
`endif

  assign adv2     = ~s2_valid_reg | out_ready;
  assign adv1     = ~s1_valid_reg | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      z_reg        <= 1'b0;
      n_reg        <= 1'b0;
      v_reg        <= 1'b0;
      ft1_reg      <= 3'b000;
      tag1_reg     <= '0;
`ifdef CMP_UNSIGNED_EN
      c_reg        <= 1'b0;
`endif
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        z_reg    <= z_next;
        n_reg    <= n_next;
        v_reg    <= v_next;
        ft1_reg  <= ft_i;
        tag1_reg <= tag_i;
`ifdef CMP_UNSIGNED_EN
        c_reg    <= c_next;
`endif
      end
    end
  end

  always_comb begin
    lt      = n_reg ^ v_reg;
    s_next  = 1'b1;
    illegal = 1'b0;
    case (ft1_reg)
      FT_EQ:  s_next = z_reg;
      FT_NEQ: s_next = ~z_reg;
      FT_LT:  s_next = lt;
      FT_LEZ: s_next = lt | z_reg;
      FT_GEZ: s_next = ~lt;
      FT_GTZ: s_next = ~lt & ~z_reg;
`ifdef CMP_UNSIGNED_EN
      FT_LTU: s_next = c_reg;
`endif
      default: begin
        s_next  = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s_reg        <= 1'b0;
      tag2_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (adv2) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s_reg    <= s_next;
          tag2_reg <= tag1_reg;
        end
      end
      // Setting wins over a simultaneous clear so the offending result is never missed.
      if (adv2 && s1_valid_reg && illegal)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign s_o       = s_reg;
  assign tag_o     = tag2_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_compare_pipe.sv
// Directed self-checking bench for compare_pipe (WIDTH=32, TAG_WIDTH=5).
module tb_compare_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [2:0]  ft_i = 3'b000;
  logic [4:0]  tag_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        s_o;
  logic [4:0]  tag_o;
  logic        err_o;
  logic        err_clr = 1'b0;

  int tests_run = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  compare_pipe #(.WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .ft_i(ft_i), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready), .s_o(s_o), .tag_o(tag_o),
    .err_o(err_o), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction for one accepting edge; returns 1 ns after that edge.
  task automatic send(input logic [2:0] ft, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    ft_i = ft; a_i = a; b_i = b; tag_i = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [2:0] ft, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic exp_s,
                         input logic exp_err);
    send(ft, a, b, tag);
    check({name, "_early"}, out_valid, 1'b0);
    tick();
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_s"}, s_o, exp_s);
    check({name, "_tag"}, tag_o, tag);
    check({name, "_err"}, err_o, exp_err);
    $display("[TB] %s ft=%b a=%h b=%h tag=%0d s=%b err=%b", name, ft, a, b, tag, s_o, err_o);
  endtask

  initial begin
    int sent;
    int recv;
    // Reset state
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s_o, 1'b0);
    check("rst_tag", tag_o, 5'd0);
    check("rst_err", err_o, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Condition evaluation, including signed-overflow and zero boundaries
    run_one("eq",        3'b001, 32'd5,        32'd5,        5'd3, 1'b1, 1'b0);
    run_one("neq",       3'b000, 32'd5,        32'd6,        5'd4, 1'b1, 1'b0);
    run_one("eq_ne",     3'b001, 32'd5,        32'd6,        5'd5, 1'b0, 1'b0);
    run_one("lt_ovf",    3'b010, 32'h80000000, 32'h00000001, 5'd6, 1'b1, 1'b0);
    run_one("lt_ovf2",   3'b010, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b0);
    run_one("lez_zero",  3'b110, 32'd0,        32'd0,        5'd8, 1'b1, 1'b0);
    run_one("gez_neg",   3'b100, 32'hFFFFFFFF, 32'd0,        5'd9, 1'b0, 1'b0);
    run_one("gtz_pos",   3'b111, 32'd1,        32'd0,        5'd10, 1'b1, 1'b0);
    run_one("gtz_zero",  3'b111, 32'd0,        32'd0,        5'd11, 1'b0, 1'b0);
    tick();
    check("idle_valid", out_valid, 1'b0);

    // Back-to-back tags 1..4 with out_ready low for four cycles
    sent = 0;
    recv = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 4);
      in_valid  = (sent < 4);
      tag_i     = 5'(sent + 1);
      ft_i      = 3'b001;
      a_i       = 32'd7;
      b_i       = 32'd7;
      #1;
      if (c == 2 || c == 3) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_valid", out_valid, 1'b1);
        check("stall_tag", tag_o, 5'd1);
        check("stall_s", s_o, 1'b1);
      end
      if (c == 4) check("resume_in_ready", in_ready, 1'b1);
      if (c >= 4 && c <= 7) check("stream_valid", out_valid, 1'b1);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("stream_tag", tag_o, 5'(recv + 1));
        $display("[TB] stream out tag=%0d s=%b cycle=%0d", tag_o, s_o, c);
        recv++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", recv, 4);
    check("stream_drained", out_valid, 1'b0);

    // Illegal code sets the sticky flag together with its result
    out_ready = 1'b1;
    run_one("illegal101", 3'b101, 32'd1, 32'd2, 5'd12, 1'b1, 1'b1);
    send(3'b101, 32'd3, 32'd3, 5'd13);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("set_clr_err", err_o, 1'b1);
    check("set_clr_s", s_o, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err", err_o, 1'b0);
    $display("[TB] err_clr alone err=%b", err_o);

`ifdef CMP_UNSIGNED_EN
    run_one("ltu",       3'b011, 32'd1,        32'hFFFFFFFF, 5'd14, 1'b1, 1'b0);
    run_one("ltu_false", 3'b011, 32'hFFFFFFFF, 32'd1,        5'd15, 1'b0, 1'b0);
`else
    run_one("ft011",     3'b011, 32'd1,        32'hFFFFFFFF, 5'd14, 1'b1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    run_one("ft011_b",   3'b011, 32'hFFFFFFFF, 32'd1,        5'd15, 1'b1, 1'b1);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Fill both stages, then reset mid-stall
    out_ready = 1'b0;
    send(3'b001, 32'd0, 32'd0, 5'd20);
    send(3'b001, 32'd0, 32'd0, 5'd21);
    tick();
    check("fill_valid", out_valid, 1'b1);
    check("fill_tag", tag_o, 5'd20);
    check("fill_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_tag", tag_o, 5'd0);
    check("arst_s", s_o, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end
    $display("[TB] reset mid-stall done");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
